// File: rtl/sequenciador_programa_pkg.sv
// sequenciador_programa_pkg
//   Shared definitions for the program sequencer: opcode constants, the
//   position of the opcode field inside a 16-bit instruction word and the
//   FSM state encoding.
package sequenciador_programa_pkg;

   localparam int OP_MSB = 8;
   localparam int OP_LSB = 6;

   localparam logic [2:0] OP_MV   = 3'b000;
   localparam logic [2:0] OP_MVI  = 3'b001;
   localparam logic [2:0] OP_ADD  = 3'b010;
   localparam logic [2:0] OP_SUB  = 3'b011;
   localparam logic [2:0] OP_HALT = 3'b111;

   typedef enum logic [3:0] {
      ST_IDLE      = 4'd0,
      ST_FETCH     = 4'd1,
      ST_LATCH     = 4'd2,
      ST_LATCH_IMM = 4'd3,
      ST_ISSUE     = 4'd4,
      ST_ISSUE_IMM = 4'd5,
      ST_WAIT_DONE = 4'd6,
      ST_HALT      = 4'd7,
      ST_ERR       = 4'd8,
      ST_STEP_WAIT = 4'd9
   } state_t;

   function automatic logic [2:0] get_opcode(input logic [15:0] word);
      return word[OP_MSB:OP_LSB];
   endfunction

endpackage

// File: rtl/sequenciador_programa_contador_timeout.sv
// contador_timeout
//   Watchdog for the processor handshake. Counts cycles while enabled and
//   flags expiry during the TIMEOUT-th consecutive enabled cycle, so the
//   owner can leave on the edge that ends that cycle.
// Ports:
//   i_clock   system clock, rising edge
//   i_reset   synchronous active-high reset
//   i_clear   restart the count (has priority over i_enable)
//   i_enable  count this cycle
//   o_expired TIMEOUT enabled cycles have elapsed without a clear
module contador_timeout #(
   parameter int TIMEOUT = 8
) (
   input  logic i_clock,
   input  logic i_reset,
   input  logic i_clear,
   input  logic i_enable,
   output logic o_expired
);

   localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

   logic [CW-1:0] r_count;

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_enable && (r_count != LIMIT)) begin
         r_count <= r_count + 1'b1;
      end
   end

   // The count holds the number of enabled cycles already completed, so
   // reaching LIMIT means the current cycle is the TIMEOUT-th one.
   assign o_expired = i_enable && (r_count == LIMIT);

endmodule

// File: rtl/sequenciador_programa.sv
// sequenciador_programa
//   Feeds a multicycle processor from a synchronous program ROM. Fetches each
//   instruction (plus the immediate for MVI), presents it on o_din with o_run
//   high until i_done, then advances the program counter. A HALT opcode stops
//   the sequence; a watchdog moves to an error state if i_done never comes.
// Optional build macro:
//   SEQ_STEP_EN  adds i_step; after each completed instruction the FSM waits
//                in STEP_WAIT for a step pulse before fetching the next one.
// Ports:
//   i_clock        system clock, rising edge
//   i_reset        synchronous active-high reset, highest priority
//   i_start        start at address 0 (only honoured in IDLE or HALT)
//   o_mem_addr     ROM address, data returns on i_mem_data one cycle later
//   i_mem_data     ROM data, opcode in bits [8:6]
//   o_din          word presented to the processor
//   o_run          processor run request
//   i_done         processor instruction-complete pulse
//   o_pc           address of the current instruction
//   o_instr_count  completed instructions (wrapping)
//   o_halted       HALT opcode reached
//   o_error        watchdog expired (cleared only by reset)
//   i_step         single-step advance (SEQ_STEP_EN builds only)
//
// state        | meaning
// -------------+-----------------------------------------------------------
// ST_IDLE      | waiting for start, run low
// ST_FETCH     | ROM address = pc
// ST_LATCH     | capture instruction word, decode opcode
// ST_LATCH_IMM | capture MVI immediate (read from pc+1)
// ST_ISSUE     | run high, din = instruction, one cycle
// ST_ISSUE_IMM | run high, din = immediate, one cycle
// ST_WAIT_DONE | run high until done
// ST_HALT      | HALT opcode reached, start restarts from address 0
// ST_ERR       | watchdog expired, left only through reset
// ST_STEP_WAIT | instruction done, waiting for a step pulse
module sequenciador_programa
   import sequenciador_programa_pkg::*;
#(
   parameter int ADDR_W  = 5,
   parameter int TIMEOUT = 8
) (
   input  logic              i_clock,
   input  logic              i_reset,
   input  logic              i_start,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [15:0]       i_mem_data,
   output logic [15:0]       o_din,
   output logic              o_run,
   input  logic              i_done,
   output logic [ADDR_W-1:0] o_pc,
   output logic [15:0]       o_instr_count,
   output logic              o_halted,
   output logic              o_error
`ifdef SEQ_STEP_EN
   ,
   input  logic              i_step
`endif
);

   state_t            r_state;
   state_t            w_next_state;
   logic [ADDR_W-1:0] r_pc;
   logic [15:0]       r_instr;
   logic [15:0]       r_imm;
   logic [15:0]       r_instr_count;

   logic              w_run_state;
   logic              w_done_acc;
   logic              w_wd_expired;
   logic              w_instr_is_mvi;
   logic [2:0]        w_data_opcode;
   logic [ADDR_W-1:0] w_pc_inc;
   state_t            w_after_done;

   assign w_run_state    = (r_state == ST_ISSUE) || (r_state == ST_ISSUE_IMM) ||
                           (r_state == ST_WAIT_DONE);
   assign w_done_acc     = w_run_state && i_done;
   assign w_instr_is_mvi = (get_opcode(r_instr) == OP_MVI);
   assign w_data_opcode  = get_opcode(i_mem_data);
   assign w_pc_inc       = w_instr_is_mvi ? ADDR_W'(2) : ADDR_W'(1);

`ifdef SEQ_STEP_EN
   assign w_after_done = ST_STEP_WAIT;
`else
   assign w_after_done = ST_FETCH;
`endif

   contador_timeout #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .i_clock   (i_clock),
      .i_reset   (i_reset),
      .i_clear   (w_done_acc),
      .i_enable  (w_run_state),
      .o_expired (w_wd_expired)
   );

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Done is tested before the watchdog so a completion on the expiry edge
   // is still accepted.
   always_comb begin
      w_next_state = r_state;
      case (r_state)
         ST_IDLE:      if (i_start) w_next_state = ST_FETCH;
         ST_FETCH:     w_next_state = ST_LATCH;
         ST_LATCH: begin
            if (w_data_opcode == OP_HALT)      w_next_state = ST_HALT;
            else if (w_data_opcode == OP_MVI)  w_next_state = ST_LATCH_IMM;
            else                               w_next_state = ST_ISSUE;
         end
         ST_LATCH_IMM: w_next_state = ST_ISSUE;
         ST_ISSUE: begin
            if (i_done)              w_next_state = w_after_done;
            else if (w_wd_expired)   w_next_state = ST_ERR;
            else if (w_instr_is_mvi) w_next_state = ST_ISSUE_IMM;
            else                     w_next_state = ST_WAIT_DONE;
         end
         ST_ISSUE_IMM: begin
            if (i_done)            w_next_state = w_after_done;
            else if (w_wd_expired) w_next_state = ST_ERR;
            else                   w_next_state = ST_WAIT_DONE;
         end
         ST_WAIT_DONE: begin
            if (i_done)            w_next_state = w_after_done;
            else if (w_wd_expired) w_next_state = ST_ERR;
         end
         ST_HALT:      if (i_start) w_next_state = ST_FETCH;
         ST_ERR:       w_next_state = ST_ERR;
`ifdef SEQ_STEP_EN
         ST_STEP_WAIT: if (i_step) w_next_state = ST_FETCH;
`endif
         default:      w_next_state = ST_IDLE;
      endcase
   end

   always_comb begin
      o_run      = w_run_state;
      o_halted   = (r_state == ST_HALT);
      o_error    = (r_state == ST_ERR);
      o_mem_addr = r_pc;
      o_din      = '0;
      case (r_state)
         // The immediate follows its opcode in ROM; the address wraps with pc.
         ST_LATCH:     if (w_data_opcode == OP_MVI) o_mem_addr = r_pc + ADDR_W'(1);
         ST_ISSUE:     o_din = r_instr;
         ST_ISSUE_IMM: o_din = r_imm;
         ST_WAIT_DONE: o_din = w_instr_is_mvi ? r_imm : r_instr;
         default:      o_din = '0;
      endcase
   end

   always_ff @(posedge i_clock) begin
      if (i_reset) begin
         r_pc          <= '0;
         r_instr       <= '0;
         r_imm         <= '0;
         r_instr_count <= '0;
      end else begin
         case (r_state)
            ST_IDLE, ST_HALT: if (i_start) r_pc <= '0;
            ST_LATCH:         r_instr <= i_mem_data;
            ST_LATCH_IMM:     r_imm   <= i_mem_data;
            default:          ;
         endcase
         if (w_done_acc) begin
            r_pc          <= r_pc + w_pc_inc;
            r_instr_count <= r_instr_count + 16'd1;
         end
      end
   end

   assign o_pc          = r_pc;
   assign o_instr_count = r_instr_count;

endmodule

// File: tb/tb_sequenciador_programa.sv
module tb_sequenciador_programa;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst;
   logic        step;

   logic        start_a, done_a;
   logic [4:0]  mem_addr_a, pc_a;
   logic [15:0] mem_data_a, din_a, count_a;
   logic        run_a, halted_a, error_a;
   logic [15:0] rom_a [32];

   logic        start_b, done_b;
   logic [1:0]  mem_addr_b, pc_b;
   logic [15:0] mem_data_b, din_b, count_b;
   logic        run_b, halted_b, error_b;
   logic [15:0] rom_b [4];

   int checks = 0;
   int errors = 0;
   logic [15:0] exp_q[$];

   sequenciador_programa dut_a (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_start       (start_a),
      .o_mem_addr    (mem_addr_a),
      .i_mem_data    (mem_data_a),
      .o_din         (din_a),
      .o_run         (run_a),
      .i_done        (done_a),
      .o_pc          (pc_a),
      .o_instr_count (count_a),
      .o_halted      (halted_a),
      .o_error       (error_a)
`ifdef SEQ_STEP_EN
      ,
      .i_step        (step)
`endif
   );

   sequenciador_programa #(.ADDR_W(2), .TIMEOUT(8)) dut_b (
      .i_clock       (clk),
      .i_reset       (rst),
      .i_start       (start_b),
      .o_mem_addr    (mem_addr_b),
      .i_mem_data    (mem_data_b),
      .o_din         (din_b),
      .o_run         (run_b),
      .i_done        (done_b),
      .o_pc          (pc_b),
      .o_instr_count (count_b),
      .o_halted      (halted_b),
      .o_error       (error_b)
`ifdef SEQ_STEP_EN
      ,
      .i_step        (1'b0)
`endif
   );

   // synchronous ROMs: data for the address seen at an edge appears after it
   always @(posedge clk) begin
      mem_data_a <= rom_a[mem_addr_a];
      mem_data_b <= rom_b[mem_addr_b];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [15:0] pop_exp();
      if (exp_q.size() == 0) return 16'hxxxx;
      return exp_q.pop_front();
   endfunction

   task automatic clear_roms();
      for (int i = 0; i < 32; i++) rom_a[i] = 16'h0000;
      for (int i = 0; i < 4; i++) rom_b[i] = 16'h0000;
   endtask

   task automatic do_reset();
      rst = 1'b1; start_a = 1'b0; done_a = 1'b0;
      start_b = 1'b0; done_b = 1'b0; step = 1'b0;
      exp_q.delete();
      tick();
      tick();
      rst = 1'b0;
   endtask

   task automatic wait_run_a(output int n);
      n = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         n++;
         if (run_a) break;
      end
      if (!run_a) begin
         checks++; errors++;
         $display("FAIL wait_run_a timeout: run=%0b required 1", run_a);
      end
   endtask

   task automatic wait_run_b(output int n);
      n = 0;
      for (int k = 0; k < 30; k++) begin
         tick();
         n++;
         if (run_b) break;
      end
      if (!run_b) begin
         checks++; errors++;
         $display("FAIL wait_run_b timeout: run=%0b required 1", run_b);
      end
   endtask

   task automatic pulse_done_a();
      done_a = 1'b1;
      tick();
      done_a = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      checks++;
      if ({run_a, halted_a, error_a} !== 3'b000 || din_a !== 16'h0 ||
          mem_addr_a !== 5'd0 || pc_a !== 5'd0 || count_a !== 16'h0) begin
         errors++;
         $display("FAIL reset_values: run=%0b halted=%0b error=%0b din=%h addr=%0d pc=%0d count=%0d required all 0",
                  run_a, halted_a, error_a, din_a, mem_addr_a, pc_a, count_a);
      end
      done_a = 1'b1;
      tick(); tick();
      done_a = 1'b0;
      checks++;
      if (run_a !== 1'b0 || pc_a !== 5'd0 || count_a !== 16'h0) begin
         errors++;
         $display("FAIL done_in_idle: run=%0b pc=%0d count=%0d required 0 0 0", run_a, pc_a, count_a);
      end
   endtask

   task automatic test_program();
      int n;
      do_reset();
      clear_roms();
      rom_a[0] = 16'h0040; rom_a[1] = 16'h0005; rom_a[2] = 16'h0080; rom_a[3] = 16'h01C0;
      exp_q.push_back(16'h0040); exp_q.push_back(16'h0005); exp_q.push_back(16'h0080);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      checks++;
      if (mem_addr_a !== 5'd0) begin
         errors++; $display("FAIL fetch_addr: got %0d required 0", mem_addr_a);
      end
      wait_run_a(n);
      checks++;
      if (n != 3) begin
         errors++; $display("FAIL mvi_latency: got %0d required 3", n);
      end
      checks++;
      begin
         logic [15:0] e = pop_exp();
         if (din_a !== e) begin
            errors++; $display("FAIL issue_mvi: din=%h required %h", din_a, e);
         end
      end
      tick();
      checks++;
      begin
         logic [15:0] e = pop_exp();
         if (din_a !== e || run_a !== 1'b1) begin
            errors++; $display("FAIL issue_imm: din=%h run=%0b required %h 1", din_a, run_a, e);
         end
      end
      tick();
      checks++;
      if (din_a !== 16'h0005 || run_a !== 1'b1) begin
         errors++; $display("FAIL imm_held: din=%h run=%0b required 0005 1", din_a, run_a);
      end
      pulse_done_a();
      checks++;
      if (run_a !== 1'b0 || pc_a !== 5'd2 || count_a !== 16'd1) begin
         errors++; $display("FAIL mvi_done: run=%0b pc=%0d count=%0d required 0 2 1", run_a, pc_a, count_a);
      end
      wait_run_a(n);
      checks++;
      if (n != 2) begin
         errors++; $display("FAIL add_latency: got %0d required 2", n);
      end
      checks++;
      begin
         logic [15:0] e = pop_exp();
         if (din_a !== e) begin
            errors++; $display("FAIL issue_add: din=%h required %h", din_a, e);
         end
      end
      pulse_done_a();
      for (int k = 0; k < 10; k++) begin
         if (halted_a) break;
         tick();
      end
      checks++;
      if (halted_a !== 1'b1 || run_a !== 1'b0 || pc_a !== 5'd3 || count_a !== 16'd2 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL halt_state: halted=%0b run=%0b pc=%0d count=%0d left=%0d required 1 0 3 2 0",
                  halted_a, run_a, pc_a, count_a, exp_q.size());
      end
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      checks++;
      if (halted_a !== 1'b0 || pc_a !== 5'd0 || mem_addr_a !== 5'd0 || count_a !== 16'd2) begin
         errors++;
         $display("FAIL restart_from_halt: halted=%0b pc=%0d addr=%0d count=%0d required 0 0 0 2",
                  halted_a, pc_a, mem_addr_a, count_a);
      end
   endtask

   task automatic test_watchdog();
      int n;
      int runc;
      do_reset();
      clear_roms();
      rom_a[0] = 16'h0080;
      exp_q.push_back(16'h0080);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_run_a(n);
      checks++;
      begin
         logic [15:0] e = pop_exp();
         if (din_a !== e) begin
            errors++; $display("FAIL wd_issue: din=%h required %h", din_a, e);
         end
      end
      runc = 1;
      for (int k = 0; k < 20; k++) begin
         tick();
         if (run_a) runc++;
         else break;
      end
      checks++;
      if (runc != 8 || error_a !== 1'b1 || run_a !== 1'b0) begin
         errors++; $display("FAIL wd_expire: run_cycles=%0d error=%0b run=%0b required 8 1 0", runc, error_a, run_a);
      end
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      tick();
      checks++;
      if (error_a !== 1'b1 || run_a !== 1'b0 || pc_a !== 5'd0) begin
         errors++; $display("FAIL err_ignores_start: error=%0b run=%0b pc=%0d required 1 0 0", error_a, run_a, pc_a);
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (error_a !== 1'b0 || run_a !== 1'b0) begin
         errors++; $display("FAIL reset_clears_error: error=%0b run=%0b required 0 0", error_a, run_a);
      end
   endtask

   task automatic test_done_at_expiry();
      int n;
      do_reset();
      clear_roms();
      rom_a[0] = 16'h0080;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_run_a(n);
      for (int k = 0; k < 7; k++) tick();
      pulse_done_a();
      checks++;
      if (error_a !== 1'b0 || run_a !== 1'b0 || pc_a !== 5'd1 || count_a !== 16'd1) begin
         errors++;
         $display("FAIL done_beats_expiry: error=%0b run=%0b pc=%0d count=%0d required 0 0 1 1",
                  error_a, run_a, pc_a, count_a);
      end
   endtask

   task automatic test_reset_in_wait();
      int n;
      do_reset();
      clear_roms();
      rom_a[0] = 16'h0080; rom_a[1] = 16'h0080;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_run_a(n);
      pulse_done_a();
      wait_run_a(n);
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checks++;
      if (run_a !== 1'b0 || pc_a !== 5'd0 || count_a !== 16'd0) begin
         errors++; $display("FAIL reset_abort: run=%0b pc=%0d count=%0d required 0 0 0", run_a, pc_a, count_a);
      end
      pulse_done_a();
      tick(); tick();
      checks++;
      if (run_a !== 1'b0 || pc_a !== 5'd0 || count_a !== 16'd0) begin
         errors++; $display("FAIL done_after_reset: run=%0b pc=%0d count=%0d required 0 0 0", run_a, pc_a, count_a);
      end
   endtask

   task automatic test_back_to_back();
      int n;
      do_reset();
      clear_roms();
      rom_a[0] = 16'h0080; rom_a[1] = 16'h00C0; rom_a[2] = 16'h01C0;
      exp_q.push_back(16'h0080); exp_q.push_back(16'h00C0);
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_run_a(n);
      checks++;
      begin
         logic [15:0] e = pop_exp();
         if (din_a !== e) begin
            errors++; $display("FAIL b2b_first: din=%h required %h", din_a, e);
         end
      end
      pulse_done_a();
      checks++;
      if (run_a !== 1'b0 || pc_a !== 5'd1 || count_a !== 16'd1) begin
         errors++; $display("FAIL done_in_issue: run=%0b pc=%0d count=%0d required 0 1 1", run_a, pc_a, count_a);
      end
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_run_a(n);
      checks++;
      begin
         logic [15:0] e = pop_exp();
         if (din_a !== e || pc_a !== 5'd1) begin
            errors++; $display("FAIL start_while_busy: din=%h pc=%0d required %h 1", din_a, pc_a, e);
         end
      end
      pulse_done_a();
      for (int k = 0; k < 10; k++) begin
         if (halted_a) break;
         tick();
      end
      checks++;
      if (halted_a !== 1'b1 || pc_a !== 5'd2 || count_a !== 16'd2) begin
         errors++; $display("FAIL b2b_halt: halted=%0b pc=%0d count=%0d required 1 2 2", halted_a, pc_a, count_a);
      end
   endtask

   task automatic test_wrap_small_rom();
      int n;
      do_reset();
      clear_roms();
      rom_b[0] = 16'h0090; rom_b[1] = 16'h00C0; rom_b[2] = 16'h0000; rom_b[3] = 16'h0040;
      exp_q.push_back(16'h0090); exp_q.push_back(16'h00C0); exp_q.push_back(16'h0000);
      exp_q.push_back(16'h0040); exp_q.push_back(16'h0090);
      start_b = 1'b1;
      tick();
      start_b = 1'b0;
      for (int i = 0; i < 3; i++) begin
         wait_run_b(n);
         checks++;
         begin
            logic [15:0] e = pop_exp();
            if (din_b !== e) begin
               errors++; $display("FAIL wrap_issue_%0d: din=%h required %h", i, din_b, e);
            end
         end
         done_b = 1'b1;
         tick();
         done_b = 1'b0;
      end
      tick();
      checks++;
      if (mem_addr_b !== 2'd0 || pc_b !== 2'd3) begin
         errors++; $display("FAIL wrap_imm_addr: addr=%0d pc=%0d required 0 3", mem_addr_b, pc_b);
      end
      wait_run_b(n);
      checks++;
      begin
         logic [15:0] e = pop_exp();
         if (din_b !== e) begin
            errors++; $display("FAIL wrap_mvi: din=%h required %h", din_b, e);
         end
      end
      tick();
      checks++;
      begin
         logic [15:0] e = pop_exp();
         if (din_b !== e) begin
            errors++; $display("FAIL wrap_imm: din=%h required %h", din_b, e);
         end
      end
      done_b = 1'b1;
      tick();
      done_b = 1'b0;
      checks++;
      if (pc_b !== 2'd1 || count_b !== 16'd4 || run_b !== 1'b0) begin
         errors++; $display("FAIL wrap_pc: pc=%0d count=%0d run=%0b required 1 4 0", pc_b, count_b, run_b);
      end
   endtask

`ifdef SEQ_STEP_EN
   task automatic test_step();
      int n;
      int runs;
      do_reset();
      clear_roms();
      rom_a[0] = 16'h0080; rom_a[1] = 16'h0080; rom_a[2] = 16'h0080; rom_a[3] = 16'h01C0;
      start_a = 1'b1;
      tick();
      start_a = 1'b0;
      wait_run_a(n);
      pulse_done_a();
      runs = 0;
      for (int k = 0; k < 5; k++) begin
         if (run_a) runs++;
         tick();
      end
      checks++;
      if (runs != 0 || pc_a !== 5'd1) begin
         errors++; $display("FAIL step_wait_holds: run_cycles=%0d pc=%0d required 0 1", runs, pc_a);
      end
      step = 1'b1;
      tick();
      step = 1'b0;
      checks++;
      if (mem_addr_a !== 5'd1 || run_a !== 1'b0) begin
         errors++; $display("FAIL step_fetch: addr=%0d run=%0b required 1 0", mem_addr_a, run_a);
      end
      wait_run_a(n);
      checks++;
      if (n != 2) begin
         errors++; $display("FAIL step_latency: got %0d required 2", n);
      end
      step = 1'b1;
      pulse_done_a();
      wait_run_a(n);
      step = 1'b0;
      checks++;
      if (n != 3 || pc_a !== 5'd2) begin
         errors++; $display("FAIL step_held: latency=%0d pc=%0d required 3 2", n, pc_a);
      end
   endtask
`endif

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1; step = 1'b0;
      start_a = 1'b0; done_a = 1'b0; start_b = 1'b0; done_b = 1'b0;
      clear_roms();
      test_reset();
      test_program();
      test_watchdog();
      test_done_at_expiry();
      test_reset_in_wait();
      test_back_to_back();
      test_wrap_small_rom();
`ifdef SEQ_STEP_EN
      test_step();
`endif
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
